// File: rtl/mmc1_pkg.sv
// mmc1_pkg: shared codes and reset constants for the MMC1 cartridge mapper.
package mmc1_pkg;

  // Register selected by CPU A14:A13 on the fifth serial write
  typedef enum logic [1:0] {
    REG_CTRL = 2'd0,
    REG_CHR0 = 2'd1,
    REG_CHR1 = 2'd2,
    REG_PRG  = 2'd3
  } reg_sel_e;

  // Mirroring select, control[1:0]
  typedef enum logic [1:0] {
    MIRROR_ONE_LO = 2'd0,
    MIRROR_ONE_HI = 2'd1,
    MIRROR_VERT   = 2'd2,
    MIRROR_HORZ   = 2'd3
  } mirror_e;

  // PRG banking mode, control[3:2]
  typedef enum logic [1:0] {
    PRG_MODE_32K_A = 2'd0,
    PRG_MODE_32K_B = 2'd1,
    PRG_MODE_FIX_LO = 2'd2,
    PRG_MODE_FIX_HI = 2'd3
  } prg_mode_e;

  // Shift register is empty when only the marker bit remains in bit 4
  localparam logic [4:0] SHIFT_INIT = 5'b10000;
  // Power-up control: PRG mode 3 (last bank fixed at $C000), 8 KB CHR, one-screen low
  localparam logic [4:0] CTRL_INIT  = 5'b01100;

endpackage

// File: rtl/mmc1_regs.sv
// mmc1_regs: CPU write edge detect, 5-bit serial shift register and the four
// mapper registers (control, chr0, chr1, prg).
module mmc1_regs
  import mmc1_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_wr,
  input  logic       i_d7,
  input  logic       i_d0,
  input  logic [1:0] i_sel,
  output logic [4:0] o_control,
  output logic [4:0] o_chr0,
  output logic [4:0] o_chr1,
  output logic [3:0] o_prg
);

  logic       r_wr_q;
  logic [4:0] r_shift;
  logic [4:0] r_control;
  logic [4:0] r_chr0;
  logic [4:0] r_chr1;
  logic [3:0] r_prg;

  logic       w_wr_edge;
  logic [4:0] w_shift_val;
  logic [4:0] w_shift_next;
  logic [4:0] w_control_next;
  logic [4:0] w_chr0_next;
  logic [4:0] w_chr1_next;
  logic [3:0] w_prg_next;

  // One event per write assertion, however long the CPU holds it
  assign w_wr_edge   = i_wr & ~r_wr_q;
  assign w_shift_val = {i_d0, r_shift[4:1]};

  // Next-state: reset-write, shift, or load on the fifth write
  always_comb begin
    w_shift_next   = r_shift;
    w_control_next = r_control;
    w_chr0_next    = r_chr0;
    w_chr1_next    = r_chr1;
    w_prg_next     = r_prg;
    if (w_wr_edge) begin
      if (i_d7) begin
        w_shift_next   = SHIFT_INIT;
        w_control_next = r_control | CTRL_INIT;
      end else if (r_shift[0]) begin
        // Marker reached bit 0: this write completes the 5-bit value
        w_shift_next = SHIFT_INIT;
        unique case (reg_sel_e'(i_sel))
          REG_CTRL: w_control_next = w_shift_val;
          REG_CHR0: w_chr0_next    = w_shift_val;
          REG_CHR1: w_chr1_next    = w_shift_val;
          REG_PRG:  w_prg_next     = w_shift_val[3:0];
        endcase
      end else begin
        w_shift_next = w_shift_val;
      end
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_q    <= 1'b0;
      r_shift   <= SHIFT_INIT;
      r_control <= CTRL_INIT;
      r_chr0    <= 5'd0;
      r_chr1    <= 5'd0;
      r_prg     <= 4'd0;
    end else begin
      r_wr_q    <= i_wr;
      r_shift   <= w_shift_next;
      r_control <= w_control_next;
      r_chr0    <= w_chr0_next;
      r_chr1    <= w_chr1_next;
      r_prg     <= w_prg_next;
    end
  end

  assign o_control = r_control;
  assign o_chr0    = r_chr0;
  assign o_chr1    = r_chr1;
  assign o_prg     = r_prg;

endmodule

// File: rtl/mmc1_cart.sv
// mmc1_cart: MMC1 (SxROM) bank-switching cartridge. Serial register writes are
// handled in mmc1_regs; this level does PRG/CHR bank mapping, CIRAM mirroring
// and data gating. Define MMC1_CHR_RAM_EN for CHR-RAM boards (PPU writes enabled).
module mmc1_cart
  import mmc1_pkg::*;
#(
  parameter  int unsigned PRG_BANK_BITS = 3,
  parameter  int unsigned CHR_BANK_BITS = 5,
  localparam int unsigned PRG_AW        = PRG_BANK_BITS + 14,
  localparam int unsigned CHR_AW        = CHR_BANK_BITS + 12
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              prg_nce_in,
  input  logic [14:0]       prg_a_in,
  input  logic              prg_r_nw_in,
  input  logic [7:0]        prg_d_in,
  output logic [7:0]        prg_d_out,
  output logic [PRG_AW-1:0] prg_rom_a_out,
  input  logic [7:0]        prg_rom_d_in,
  input  logic [13:0]       chr_a_in,
  input  logic              chr_r_nw_in,
  input  logic [7:0]        chr_d_in,
  output logic [7:0]        chr_d_out,
  output logic [CHR_AW-1:0] chr_mem_a_out,
  input  logic [7:0]        chr_mem_d_in,
  output logic [7:0]        chr_mem_d_out,
  output logic              chr_mem_we_out,
  output logic              ciram_nce_out,
  output logic              ciram_a10_out
);

  logic                     w_wr;
  logic [4:0]               w_control;
  logic [4:0]               w_chr0;
  logic [4:0]               w_chr1;
  logic [3:0]               w_prg;
  logic [PRG_BANK_BITS-1:0] w_prg_bank;
  logic [CHR_BANK_BITS-1:0] w_chr_bank;
  logic                     w_unused_d;

  // Only bits 7 and 0 of write data matter to the mapper
  assign w_unused_d = ^prg_d_in[6:1];
  assign w_wr       = ~prg_nce_in & ~prg_r_nw_in;

  mmc1_regs u_regs (
    .i_clk     (clk_in),
    .i_rst     (rst_in),
    .i_wr      (w_wr),
    .i_d7      (prg_d_in[7]),
    .i_d0      (prg_d_in[0]),
    .i_sel     (prg_a_in[14:13]),
    .o_control (w_control),
    .o_chr0    (w_chr0),
    .o_chr1    (w_chr1),
    .o_prg     (w_prg)
  );

  // PRG bank select; size casts drop excess bank bits so large banks wrap
  always_comb begin
    w_prg_bank = '0;
    unique case (prg_mode_e'(w_control[3:2]))
      PRG_MODE_32K_A, PRG_MODE_32K_B:
        w_prg_bank = PRG_BANK_BITS'({w_prg[3:1], prg_a_in[14]});
      PRG_MODE_FIX_LO:
        w_prg_bank = prg_a_in[14] ? PRG_BANK_BITS'(w_prg) : '0;
      PRG_MODE_FIX_HI:
        w_prg_bank = prg_a_in[14] ? '1 : PRG_BANK_BITS'(w_prg);
    endcase
  end

  // CHR bank select: one 8 KB bank from chr0, or two independent 4 KB banks
  always_comb begin
    w_chr_bank = '0;
    if (!w_control[4]) begin
      w_chr_bank = CHR_BANK_BITS'({w_chr0[4:1], chr_a_in[12]});
    end else if (chr_a_in[12]) begin
      w_chr_bank = CHR_BANK_BITS'(w_chr1);
    end else begin
      w_chr_bank = CHR_BANK_BITS'(w_chr0);
    end
  end

  // Nametable mirroring
  always_comb begin
    ciram_a10_out = 1'b0;
    unique case (mirror_e'(w_control[1:0]))
      MIRROR_ONE_LO: ciram_a10_out = 1'b0;
      MIRROR_ONE_HI: ciram_a10_out = 1'b1;
      MIRROR_VERT:   ciram_a10_out = chr_a_in[10];
      MIRROR_HORZ:   ciram_a10_out = chr_a_in[11];
    endcase
  end

  assign prg_rom_a_out = {w_prg_bank, prg_a_in[13:0]};
  assign chr_mem_a_out = {w_chr_bank, chr_a_in[11:0]};

  assign prg_d_out     = prg_nce_in ? 8'h00 : prg_rom_d_in;
  assign chr_d_out     = chr_a_in[13] ? 8'h00 : chr_mem_d_in;
  assign chr_mem_d_out = chr_d_in;
  assign ciram_nce_out = ~chr_a_in[13];

`ifdef MMC1_CHR_RAM_EN
  assign chr_mem_we_out = ~chr_r_nw_in & ~chr_a_in[13];
`else
  logic w_unused_chr_r_nw;
  assign w_unused_chr_r_nw = chr_r_nw_in;
  assign chr_mem_we_out    = 1'b0;
`endif

endmodule
